// File: rtl/div_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the multi-cycle DIV/DIVU controller.
//   DIV_WIDTH   default operand width (quotient and remainder are each this wide)
//   divState_t  controller state encoding
//   isPending   true for the states in which the divider is still working
// ----------------------------------------------------------------------------
package div_ctrl_pkg;

    localparam int DIV_WIDTH = 32;

    // DIV_FREE is the idle state; DIV_BYZERO is the short path taken when the
    // divisor is zero; DIV_ON runs the restoring steps; DIV_END publishes.
    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } divState_t;

    // States that must keep the front of the pipeline frozen regardless of
    // what the request line is doing.
    function automatic logic isPending(input divState_t s);
        return (s == DIV_ON) || (s == DIV_BYZERO);
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// ----------------------------------------------------------------------------
// div_ctrl_if
// Request/response bundle between the EX stage and the divide controller.
//   start       request, held until ready or annul          (master -> slave)
//   signed_div  1 = DIV, 0 = DIVU                           (master -> slave)
//   opa, opb    dividend / divisor                          (master -> slave)
//   annul       flush, aborts any operation                 (master -> slave)
//   stall_req   freeze IF..EX while the divide is pending   (slave -> master)
//   result      {remainder, quotient}                       (slave -> master)
//   ready       one-cycle pulse, result valid               (slave -> master)
// ----------------------------------------------------------------------------
interface div_ctrl_if
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               annul;
    logic               stall_req;
    logic [2*WIDTH-1:0] result;
    logic               ready;

    // The pipeline side issues requests and consumes the result.
    modport master (
        output start, signed_div, opa, opb, annul,
        input  stall_req, result, ready
    );

    // The divider side serves requests.
    modport slave (
        input  start, signed_div, opa, opb, annul,
        output stall_req, result, ready
    );

endinterface

// File: rtl/div_ctrl_step.sv
// ----------------------------------------------------------------------------
// div_ctrl_step
// One combinational restoring-division step.
//   i_partial  WIDTH+1  previous remainder with the next dividend bit appended
//   i_divisor  WIDTH    divisor magnitude
//   o_rem      WIDTH    next partial remainder
//   o_qbit     1        quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_ctrl_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_partial,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH-1:0] w_diff;

    // The incoming remainder is always below the divisor, so the shifted
    // value is below twice the divisor. If its top bit is set it is certainly
    // >= divisor, and the true difference is then < divisor, so computing the
    // subtraction modulo 2^WIDTH still gives the exact result.
    assign o_qbit = i_partial[WIDTH] | (i_partial[WIDTH-1:0] >= i_divisor);
    assign w_diff = i_partial[WIDTH-1:0] - i_divisor;
    assign o_rem  = o_qbit ? w_diff : i_partial[WIDTH-1:0];

endmodule

// File: rtl/div_ctrl.sv
// ----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle DIV/DIVU controller for the EX stage. Accepts one request,
// latches operand magnitudes and signs, runs WIDTH restoring steps, applies
// the sign fix-up and presents {remainder, quotient} with a ready pulse.
//   clk     system clock, rising edge
//   rst     synchronous reset, active-high (also clears result)
//   io_div  div_ctrl_if slave: start/signed_div/opa/opb/annul in,
//           stall_req (combinational)/result/ready (registered) out
// ----------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave io_div
);

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    divState_t          r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_negQ;
    logic               r_negR;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic [WIDTH-1:0]   w_opaMag;
    logic [WIDTH-1:0]   w_opbMag;
    logic [WIDTH-1:0]   w_stepRem;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_quoFix;
    logic [WIDTH-1:0]   w_remFix;

    // Operand magnitudes for DIV. Negating the most negative value yields
    // itself, which read as unsigned is exactly its magnitude.
    assign w_opaMag = (io_div.signed_div && io_div.opa[WIDTH-1]) ? -io_div.opa : io_div.opa;
    assign w_opbMag = (io_div.signed_div && io_div.opb[WIDTH-1]) ? -io_div.opb : io_div.opb;

    // The dividend register doubles as the quotient shift register: each step
    // consumes its MSB and shifts the new quotient bit into the LSB.
    div_ctrl_step #(.WIDTH(WIDTH)) u_step (
        .i_partial (({r_rem, r_dividend[WIDTH-1]})),
        .i_divisor (r_divisor),
        .o_rem     (w_stepRem),
        .o_qbit    (w_qbit)
    );

    // Sign fix-up: quotient negative when operand signs differ, remainder
    // follows the dividend. Both flags are zero for DIVU and divide-by-zero.
    assign w_quoFix = r_negQ ? -r_dividend : r_dividend;
    assign w_remFix = r_negR ? -r_rem : r_rem;

    // Main controller. Annul returns to idle from any state without touching
    // result, and because it is checked first it also beats a new request in
    // idle and the publish in DIV_END. The divide-by-zero path stages
    // {opa, all ones} into the remainder/quotient registers with no sign
    // correction so that DIV_END remains the only place result is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (io_div.annul) begin
                r_state <= DIV_FREE;
            end else begin
                case (r_state)
                    DIV_FREE: begin
                        if (io_div.start) begin
                            r_cnt <= '0;
                            if (io_div.opb == '0) begin
                                r_dividend <= io_div.opa;
                                r_state    <= DIV_BYZERO;
                            end else begin
                                r_dividend <= w_opaMag;
                                r_divisor  <= w_opbMag;
                                r_rem      <= '0;
                                r_negQ     <= io_div.signed_div &
                                              (io_div.opa[WIDTH-1] ^ io_div.opb[WIDTH-1]);
                                r_negR     <= io_div.signed_div & io_div.opa[WIDTH-1];
                                r_state    <= DIV_ON;
                            end
                        end
                    end
                    DIV_BYZERO: begin
                        r_rem      <= r_dividend;
                        r_dividend <= '1;
                        r_negQ     <= 1'b0;
                        r_negR     <= 1'b0;
                        r_state    <= DIV_END;
                    end
                    DIV_ON: begin
                        r_rem      <= w_stepRem;
                        r_dividend <= {r_dividend[WIDTH-2:0], w_qbit};
                        r_cnt      <= r_cnt + 1'b1;
                        if (r_cnt == LAST_STEP) begin
                            r_state <= DIV_END;
                        end
                    end
                    DIV_END: begin
                        r_result <= {w_remFix, w_quoFix};
                        r_ready  <= 1'b1;
                        r_state  <= DIV_FREE;
                    end
                    default: begin
                        r_state <= DIV_FREE;
                    end
                endcase
            end
        end
    end

    // Freeze IF..EX while a request waits or the divider is working; release
    // in DIV_END so the instruction leaves EX on the edge that writes result.
    assign io_div.stall_req = !io_div.annul &&
                              (((r_state == DIV_FREE) && io_div.start) || isPending(r_state));

    assign io_div.result = r_result;
    assign io_div.ready  = r_ready;

endmodule

// File: tb/tb_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl (WIDTH = 32): directed vector table,
// multi-cycle corner sequences and randomized DIV/DIVU against a reference.
// ----------------------------------------------------------------------------
module tb_div_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edgeCount = 0;
    int   nChecks = 0;
    int   nFails = 0;

    div_ctrl_if #(.WIDTH(32)) bus ();

    div_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_div (bus)
    );

    // Free-running clock and an edge counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        edgeCount <= edgeCount + 1;
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expRes;
        int          expLat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic division, which truncates toward
    // zero with the remainder taking the dividend's sign, then truncated to
    // 32 bits. Division by zero yields {dividend, all ones}.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one request, scramble the operands after acceptance, and wait
    // (bounded) for ready. hsOk requires stall_req high before acceptance and
    // while working, low in exactly the cycle before ready, low in the ready
    // cycle once start drops, and ready lasting a single cycle.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [63:0] res, output int lat, output logic hsOk);
        int   acceptEdge;
        int   lowCnt;
        logic lastLow;
        logic seen;
        bus.signed_div = sgn;
        bus.opa        = a;
        bus.opb        = b;
        bus.start      = 1'b1;
        #1;
        hsOk = bus.stall_req;
        @(posedge clk);
        #1;
        acceptEdge     = edgeCount;
        bus.opa        = ~a;
        bus.opb        = b ^ 32'h5;
        bus.signed_div = ~sgn;
        lowCnt  = 0;
        lastLow = 1'b0;
        seen    = 1'b0;
        lat     = -1;
        res     = '0;
        for (int k = 0; k < 100 && !seen; k++) begin
            lastLow = !bus.stall_req;
            if (lastLow) lowCnt++;
            @(posedge clk);
            #1;
            if (bus.ready) begin
                seen = 1'b1;
                lat  = edgeCount - acceptEdge;
                res  = bus.result;
            end
        end
        bus.start = 1'b0;
        #1;
        hsOk = hsOk && seen && (lowCnt == 1) && lastLow && !bus.stall_req;
        @(posedge clk);
        #1;
        hsOk = hsOk && !bus.ready;
    endtask

    // Bounded wait for the next ready pulse; at stays -1 on timeout.
    task automatic waitReady(output int at, output logic [63:0] res);
        at  = -1;
        res = '0;
        for (int k = 0; k < 100 && at < 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                at  = edgeCount;
                res = bus.result;
            end
        end
    endtask

    // Watch n cycles and report whether any ready pulse appeared.
    task automatic watchNoReady(input int n, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready) seen = 1'b1;
        end
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] res2;
        logic [63:0] prevRes;
        logic [63:0] expRes;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        hs;
        logic        seen;
        int          lat;
        int          accept1;
        int          e1;
        int          e2;

        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opa        = '0;
        bus.opb        = '0;
        bus.annul      = 1'b0;

        vecs.push_back('{1'b0, 32'h0000_0007, 32'h0000_0002, {32'h0000_0001, 32'h0000_0003}, 33, "divu_7_2"});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2"});
        vecs.push_back('{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, "div_7_m2"});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, "div_min_m1"});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF}, 33, "divu_max_1"});
        vecs.push_back('{1'b1, 32'h1234_5678, 32'h0000_0000, {32'h1234_5678, 32'hFFFF_FFFF}, 2,  "div_by_zero"});
        vecs.push_back('{1'b0, 32'h0000_0064, 32'h0000_0007, {32'h0000_0002, 32'h0000_000E}, 33, "divu_100_7"});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result", bus.result, 64'd0);
        checkOutput("reset_ready", {63'd0, bus.ready}, 64'd0);
        checkOutput("reset_stall", {63'd0, bus.stall_req}, 64'd0);
        rst = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat, hs);
            checkOutput({vecs[i].name, "_result"}, res, vecs[i].expRes);
            checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].expLat));
            checkOutput({vecs[i].name, "_handshake"}, {63'd0, hs}, 64'd1);
        end

        // Back-to-back with start held high: DIVU 9/4 then DIVU 10/3.
        bus.signed_div = 1'b0;
        bus.opa        = 32'd9;
        bus.opb        = 32'd4;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        accept1 = edgeCount;
        bus.opa = 32'd10;
        bus.opb = 32'd3;
        waitReady(e1, res);
        waitReady(e2, res2);
        bus.start = 1'b0;
        checkOutput("b2b_first_latency", 64'(e1 - accept1), 64'd33);
        checkOutput("b2b_spacing", 64'(e2 - e1), 64'd34);
        checkOutput("b2b_first_result", res, {32'd1, 32'd2});
        checkOutput("b2b_second_result", res2, {32'd1, 32'd3});
        @(posedge clk);
        #1;

        // Annul at step 10: back to idle, no ready, result preserved.
        prevRes        = bus.result;
        bus.opa        = 32'd1000;
        bus.opb        = 32'd3;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        bus.start = 1'b0;
        #1;
        checkOutput("annul_stall_gated", {63'd0, bus.stall_req}, 64'd0);
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        #1;
        checkOutput("annul_idle_stall", {63'd0, bus.stall_req}, 64'd0);
        watchNoReady(40, seen);
        checkOutput("annul_no_ready", {63'd0, seen}, 64'd0);
        checkOutput("annul_result_kept", bus.result, prevRes);
        applyStimulus(1'b0, 32'd100, 32'd7, res, lat, hs);
        checkOutput("after_annul_result", res, {32'd2, 32'd14});
        checkOutput("after_annul_latency", 64'(lat), 64'd33);

        // Annul in the publish cycle suppresses both ready and the write.
        prevRes   = bus.result;
        bus.opa   = 32'd50;
        bus.opb   = 32'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        repeat (32) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        checkOutput("annul_end_no_ready", {63'd0, bus.ready}, 64'd0);
        watchNoReady(40, seen);
        checkOutput("annul_end_quiet", {63'd0, seen}, 64'd0);
        checkOutput("annul_end_result_kept", bus.result, prevRes);

        // Annul beats a request in idle.
        bus.opa   = 32'd5;
        bus.opb   = 32'd1;
        bus.start = 1'b1;
        bus.annul = 1'b1;
        #1;
        checkOutput("annul_idle_prio_stall", {63'd0, bus.stall_req}, 64'd0);
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        bus.start = 1'b0;
        #1;
        checkOutput("annul_idle_not_started", {63'd0, bus.stall_req}, 64'd0);
        watchNoReady(40, seen);
        checkOutput("annul_idle_no_ready", {63'd0, seen}, 64'd0);

        // Reset at step 10: idle, no ready, result cleared.
        bus.opa   = 32'd1000;
        bus.opb   = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_mid_result", bus.result, 64'd0);
        checkOutput("rst_mid_stall", {63'd0, bus.stall_req}, 64'd0);
        watchNoReady(40, seen);
        checkOutput("rst_mid_no_ready", {63'd0, seen}, 64'd0);
        checkOutput("rst_mid_result_held", bus.result, 64'd0);
        applyStimulus(1'b0, 32'd100, 32'd7, res, lat, hs);
        checkOutput("after_rst_result", res, {32'd2, 32'd14});

        // Randomized DIV/DIVU against the arithmetic reference.
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (n == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            expRes = refDiv(rs, ra, rb);
            applyStimulus(rs, ra, rb, res, lat, hs);
            checkOutput($sformatf("rand%0d_%s_%h_%h", n, rs ? "div" : "divu", ra, rb), res, expRes);
            checkOutput($sformatf("rand%0d_latency", n), 64'(lat), (rb == 32'd0) ? 64'd2 : 64'd33);
            checkOutput($sformatf("rand%0d_handshake", n), {63'd0, hs}, 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
